mem_multicycle_responder: RTL and testbench
===========================================

Name: mem_multicycle_responder

Overview:
- Responder end of the CPU data/instruction memory interface.
- Accepts the same request signals the pipeline drives (enable, wr, addr, data_in). Completes writes at acceptance.
- Returns read data a fixed LATENCY cycles later with a valid strobe. Accepts a new request every cycle.
- Replaces the single-cycle memory for multi-cycle memory and cache-fill work. Also supports a pipeline flush that cancels in-flight reads.

Parameters:
- LATENCY, 4, cycles from read acceptance edge to data_valid high; legal range 1..8.
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.
- WORDS_LOG2, 15, log2 of array depth in words; word index = addr[WORDS_LOG2:1].

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  request present this cycle.
- wr  input  1  1 = write, 0 = read; qualified by enable.
- addr  input  ADDR_W  byte address of request.
- data_in  input  DATA_W  write data.
- flush  input  1  cancel all in-flight reads.
- tag_in  input  4  requester tag, returned with read data.
- data_out  output  DATA_W  read data; valid only when data_valid=1.
- data_valid  output  1  one-cycle strobe per completed read.
- tag_out  output  4  tag of the read currently on data_out.
- busy  output  1  high while any read is in flight.

Behaviour:
- Reset is asynchronous, active-low:
  - data_valid=0, busy=0, data_out=0, tag_out=0.
  - All in-flight slots are cleared.
  - Array contents are NOT reset and are retained across rst_n.
- Acceptance: every cycle with enable=1 is accepted. There is no backpressure and no ready signal.
- Write (enable=1, wr=1): array[addr index] <= data_in on that edge. No response is generated.
- Read (enable=1, wr=0):
  - Array word is sampled on the acceptance edge, after any write committed on an earlier edge. Read-after-write in the next cycle returns the new data.
  - {valid, data, tag} then travels a LATENCY-deep slot pipeline.
  - data_valid=1 exactly LATENCY cycles after the acceptance edge, for one cycle.
- Back-to-back reads on N consecutive cycles give N consecutive data_valid cycles, in order, with matching tags.
- enable=0 cycles produce bubbles (data_valid=0) at the matching output position.
- When data_valid=0, data_out and tag_out hold their last driven values.
- busy = OR of all slot valid bits.
- flush=1 on an edge:
  - Clears the valid bit of every occupied slot; data_valid stays 0 for those reads.
  - A read accepted on the same edge as flush is NOT cancelled and completes normally.
  - A write on the flush edge commits normally.
- LATENCY=1: slot pipeline is a single register; same rules apply.
- Address wrap: addr bits above WORDS_LOG2 are ignored (aliasing).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Extra output port align_err (1 bit, reset 0).
  - A request with addr[0]=1 is flagged misaligned.
  - Misaligned write: suppressed (array unchanged), and align_err pulses 1 the cycle after acceptance.
  - Misaligned read: travels the pipeline normally, but returns data_out=0 with align_err=1 in the same cycle as its data_valid.
  - Flush cancels the error pulse along with the read.
- Not defined: no align_err port; addr[0] is ignored, so odd addresses access the enclosing word.

Test Plan:
- Write 0xBEEF at addr 0x0010, then read 0x0010 on the very next cycle with tag 3 (LATENCY=4) -> data_valid high exactly 4 cycles after the read edge, data_out=0xBEEF, tag_out=3, busy high for those 4 cycles.
- Reads of 0x0000, 0x0002, 0x0004 on 3 consecutive cycles, tags 1,2,3, array preloaded 0x1111/0x2222/0x3333 -> three consecutive data_valid cycles, same data and tag order.
- Read A (tag 5) at cycle 0, idle cycle 1, read B (tag 6) at cycle 2 -> valid at cycles 4 and 6, bubble at 5.
- Reads at cycles 0 and 1, flush=1 together with a new read (tag 9) at cycle 2 -> reads from cycles 0 and 1 never produce data_valid; tag 9 read returns at cycle 6.
- Read in flight, rst_n pulsed low mid-cycle for 1 cycle -> data_valid and busy drop to 0 immediately, no response after reset deasserts; a subsequent read of the previously written word still returns 0xBEEF (array retained).
- With MEM_ALIGN_CHECK_EN: write 0x1234 to odd addr 0x0011 -> array word 0x0010 unchanged, align_err=1 one cycle later. Read odd addr 0x0011 -> data_out=0, align_err=1 coincident with data_valid.

Source files
------------

// File: rtl/mem_multicycle_responder.sv
// mem_multicycle_responder
//
// Responder end of the CPU data/instruction memory interface. Requests are
// accepted every cycle that enable is high. There is no backpressure.
// Writes commit on the acceptance edge. Reads sample the array on the
// acceptance edge and travel a LATENCY-deep slot pipeline. The last slot
// drives data_out/tag_out/data_valid, so a read is returned LATENCY cycles
// after it was presented. flush drops every read already in flight. A read
// accepted on the flush edge is kept.
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   defined   : adds align_err. An odd-address write is suppressed and pulses
//               align_err on the next cycle. An odd-address read returns
//               data_out=0 with align_err alongside data_valid.
//   undefined : addr[0] is ignored. Odd addresses alias the enclosing word.
//
// Ports
//   clk, rst_n      clock, async active-low reset (array contents kept)
//   enable, wr      request strobe, 1 = write / 0 = read
//   addr, data_in   byte address, write data
//   flush           cancel all in-flight reads
//   tag_in/tag_out  requester tag, returned with read data
//   data_out        read data, held while data_valid is low
//   data_valid      one-cycle strobe per completed read
//   busy            any read in flight
//   align_err       misalignment flag (MEM_ALIGN_CHECK_EN only)
module mem_multicycle_responder #(
   parameter int LATENCY    = 4,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int WORDS_LOG2 = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              flush,
   input  logic [3:0]        tag_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [3:0]        tag_out,
   output logic              busy
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic              align_err
`endif
);

   localparam int DEPTH = 1 << WORDS_LOG2;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [WORDS_LOG2-1:0] word_idx;
   logic                  misaligned;
   logic                  rd_accept;
   logic                  wr_commit;

   logic [LATENCY-1:0]    slot_v;
   logic [LATENCY-1:0]    slot_e;
   logic [DATA_W-1:0]     slot_d [LATENCY];
   logic [3:0]            slot_t [LATENCY];
   logic                  wr_err_q;
   logic                  align_err_int;

   assign word_idx = addr[WORDS_LOG2:1];

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = addr[0];
   assign align_err  = align_err_int;
`else
   logic unused_align;
   assign misaligned   = 1'b0;
   assign unused_align = align_err_int ^ addr[0];
`endif

   assign rd_accept = enable & ~wr;
   assign wr_commit = enable & wr & ~misaligned;

   // The array has no reset, so its contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_commit) begin
         mem[word_idx] <= data_in;
      end
   end

   // Each slot loads its data and tag only when a live entry moves in. The
   // last slot therefore keeps showing the most recent read between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_v   <= '0;
         slot_e   <= '0;
         wr_err_q <= 1'b0;
         for (int k = 0; k < LATENCY; k++) begin
            slot_d[k] <= '0;
            slot_t[k] <= '0;
         end
      end else begin
         wr_err_q  <= enable & wr & misaligned;
         slot_v[0] <= rd_accept;
         if (rd_accept) begin
            slot_d[0] <= misaligned ? '0 : mem[word_idx];
            slot_t[0] <= tag_in;
            slot_e[0] <= misaligned;
         end
         // flush kills only entries already in flight. Slot 0 is fed by the
         // request on this same edge, so that request is never cancelled.
         for (int k = 1; k < LATENCY; k++) begin
            slot_v[k] <= slot_v[k-1] & ~flush;
            if (slot_v[k-1] & ~flush) begin
               slot_d[k] <= slot_d[k-1];
               slot_t[k] <= slot_t[k-1];
               slot_e[k] <= slot_e[k-1];
            end
         end
      end
   end

   assign data_valid    = slot_v[LATENCY-1];
   assign data_out      = slot_d[LATENCY-1];
   assign tag_out       = slot_t[LATENCY-1];
   assign busy          = |slot_v;
   assign align_err_int = wr_err_q | (slot_v[LATENCY-1] & slot_e[LATENCY-1]);

endmodule

// File: tb/tb_mem_multicycle_responder.sv
module tb_mem_multicycle_responder;

   localparam int LAT  = 4;
   localparam int HLEN = 4096;
`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct {
      logic        en;
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      logic [3:0]  t;
      logic        fl;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable, wr, flush;
   logic [15:0] addr, data_in;
   logic [3:0]  tag_in;
   logic [15:0] data_out;
   logic        data_valid;
   logic [3:0]  tag_out;
   logic        busy;
   logic        obs_ae;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Expected-response schedule, indexed by sample number. Sample s is taken
   // at the falling edge after the rising edge that ends cycle s-1.
   bit          exp_v  [HLEN];
   bit          exp_e  [HLEN];
   bit          exp_we [HLEN];
   logic [15:0] exp_d  [HLEN];
   logic [3:0]  exp_t  [HLEN];
   logic [15:0] mdl_mem [int];
   logic [15:0] last_d;
   logic [3:0]  last_t;
   logic        e_v, e_b, e_ae;

   mem_multicycle_responder #(
      .LATENCY(LAT), .ADDR_W(16), .DATA_W(16), .WORDS_LOG2(15)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
      .data_in(data_in), .flush(flush), .tag_in(tag_in),
      .data_out(data_out), .data_valid(data_valid), .tag_out(tag_out),
      .busy(busy)
`ifdef MEM_ALIGN_CHECK_EN
      , .align_err(obs_ae)
`endif
   );

`ifndef MEM_ALIGN_CHECK_EN
   assign obs_ae = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic stim_t mk(input logic en, input logic w, input logic [15:0] a,
                                input logic [15:0] d, input logic [3:0] t, input logic fl);
      stim_t s;
      s.en = en; s.w = w; s.a = a; s.d = d; s.t = t; s.fl = fl;
      return s;
   endfunction

   function automatic stim_t idle();
      return mk(1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
   endfunction

   // Apply one cycle of stimulus, advance the behavioural model, and move to
   // the next sample point with the expected outputs in e_v/e_b/last_d/last_t/e_ae.
   task automatic drive_cycle(input stim_t s);
      int   idx;
      logic odd;
      enable = s.en; wr = s.w; addr = s.a; data_in = s.d; tag_in = s.t; flush = s.fl;
      idx = int'(s.a[15:1]);
      odd = ALIGN & s.a[0];
      if (s.fl) begin
         for (int k = cyc + 1; k < cyc + LAT; k++) begin
            exp_v[k] = 1'b0;
            exp_e[k] = 1'b0;
         end
      end
      if (s.en && !s.w) begin
         exp_v[cyc+LAT] = 1'b1;
         exp_e[cyc+LAT] = odd;
         exp_d[cyc+LAT] = odd ? 16'h0 : mdl_mem[idx];
         exp_t[cyc+LAT] = s.t;
      end
      if (s.en && s.w) begin
         if (odd) exp_we[cyc+1] = 1'b1;
         else     mdl_mem[idx] = s.d;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (exp_v[cyc]) begin
         last_d = exp_d[cyc];
         last_t = exp_t[cyc];
      end
      e_v = exp_v[cyc];
      e_b = 1'b0;
      for (int k = cyc; k < cyc + LAT; k++) e_b |= exp_v[k];
      e_ae = exp_we[cyc] | (exp_v[cyc] & exp_e[cyc]);
   endtask

   task automatic clear_model();
      for (int k = 0; k < HLEN; k++) begin
         exp_v[k] = 1'b0; exp_e[k] = 1'b0; exp_we[k] = 1'b0;
      end
      last_d = 16'h0; last_t = 4'h0;
      e_v = 1'b0; e_b = 1'b0; e_ae = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
      tag_in = '0; flush = 1'b0;
      clear_model();
      #3;
      if ({data_valid, busy, data_out, tag_out, obs_ae} !== 23'h0) begin
         failures++;
         $display("FAIL reset_async got v=%b b=%b d=%h t=%h ae=%b want all zero",
                  data_valid, busy, data_out, tag_out, obs_ae);
      end
      checks++;
      enable = 1'b1; // a request during reset must not take effect
      @(posedge clk); @(negedge clk);
      enable = 1'b0;
      if ({data_valid, busy, data_out, tag_out, obs_ae} !== 23'h0) begin
         failures++;
         $display("FAIL reset_hold got v=%b b=%b d=%h t=%h ae=%b want all zero",
                  data_valid, busy, data_out, tag_out, obs_ae);
      end
      checks++;
      rst_n = 1'b1;
   endtask

   task automatic test_raw_latency();
      stim_t q[$];
      q.push_back(mk(1, 1, 16'h0010, 16'hBEEF, 0, 0));
      q.push_back(mk(1, 0, 16'h0010, 16'h0000, 3, 0));
      repeat (LAT + 2) q.push_back(idle());
      foreach (q[i]) begin
         drive_cycle(q[i]);
         if ({data_valid, busy, data_out, tag_out, obs_ae} !== {e_v, e_b, last_d, last_t, e_ae}) begin
            failures++;
            $display("FAIL raw_latency cyc=%0d got v=%b b=%b d=%h t=%h ae=%b want v=%b b=%b d=%h t=%h ae=%b",
                     cyc, data_valid, busy, data_out, tag_out, obs_ae, e_v, e_b, last_d, last_t, e_ae);
         end
         checks++;
      end
   endtask

   task automatic test_back_to_back();
      stim_t q[$];
      q.push_back(mk(1, 1, 16'h0000, 16'h1111, 0, 0));
      q.push_back(mk(1, 1, 16'h0002, 16'h2222, 0, 0));
      q.push_back(mk(1, 1, 16'h0004, 16'h3333, 0, 0));
      q.push_back(mk(1, 0, 16'h0000, 16'h0, 1, 0));
      q.push_back(mk(1, 0, 16'h0002, 16'h0, 2, 0));
      q.push_back(mk(1, 0, 16'h0004, 16'h0, 3, 0));
      repeat (LAT + 2) q.push_back(idle());
      foreach (q[i]) begin
         drive_cycle(q[i]);
         if ({data_valid, busy, data_out, tag_out, obs_ae} !== {e_v, e_b, last_d, last_t, e_ae}) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got v=%b b=%b d=%h t=%h ae=%b want v=%b b=%b d=%h t=%h ae=%b",
                     cyc, data_valid, busy, data_out, tag_out, obs_ae, e_v, e_b, last_d, last_t, e_ae);
         end
         checks++;
      end
   endtask

   task automatic test_bubble();
      stim_t q[$];
      q.push_back(mk(1, 0, 16'h0000, 16'h0, 5, 0));
      q.push_back(idle());
      q.push_back(mk(1, 0, 16'h0004, 16'h0, 6, 0));
      repeat (LAT + 2) q.push_back(idle());
      foreach (q[i]) begin
         drive_cycle(q[i]);
         if ({data_valid, busy, data_out, tag_out, obs_ae} !== {e_v, e_b, last_d, last_t, e_ae}) begin
            failures++;
            $display("FAIL bubble cyc=%0d got v=%b b=%b d=%h t=%h ae=%b want v=%b b=%b d=%h t=%h ae=%b",
                     cyc, data_valid, busy, data_out, tag_out, obs_ae, e_v, e_b, last_d, last_t, e_ae);
         end
         checks++;
      end
   endtask

   task automatic test_flush();
      stim_t q[$];
      q.push_back(mk(1, 0, 16'h0000, 16'h0, 7, 0));
      q.push_back(mk(1, 0, 16'h0002, 16'h0, 8, 0));
      q.push_back(mk(1, 0, 16'h0004, 16'h0, 9, 1));
      q.push_back(idle());
      q.push_back(mk(1, 0, 16'h0000, 16'h0, 10, 0));
      q.push_back(mk(1, 1, 16'h0006, 16'h4444, 0, 1)); // write on a flush edge
      q.push_back(mk(1, 0, 16'h0006, 16'h0, 11, 0));
      repeat (LAT + 2) q.push_back(idle());
      foreach (q[i]) begin
         drive_cycle(q[i]);
         if ({data_valid, busy, data_out, tag_out, obs_ae} !== {e_v, e_b, last_d, last_t, e_ae}) begin
            failures++;
            $display("FAIL flush cyc=%0d got v=%b b=%b d=%h t=%h ae=%b want v=%b b=%b d=%h t=%h ae=%b",
                     cyc, data_valid, busy, data_out, tag_out, obs_ae, e_v, e_b, last_d, last_t, e_ae);
         end
         checks++;
      end
   endtask

   task automatic test_reset_midflight();
      stim_t q[$];
      drive_cycle(mk(1, 0, 16'h0010, 16'h0, 4, 0));
      drive_cycle(idle());
      if ({data_valid, busy} !== {e_v, e_b}) begin
         failures++;
         $display("FAIL midreset_pre cyc=%0d got v=%b b=%b want v=%b b=%b",
                  cyc, data_valid, busy, e_v, e_b);
      end
      checks++;
      #2 rst_n = 1'b0;
      #1;
      if ({data_valid, busy, data_out, tag_out, obs_ae} !== 23'h0) begin
         failures++;
         $display("FAIL midreset_drop got v=%b b=%b d=%h t=%h ae=%b want all zero",
                  data_valid, busy, data_out, tag_out, obs_ae);
      end
      checks++;
      @(posedge clk); @(negedge clk);
      cyc++;
      rst_n = 1'b1;
      clear_model();
      repeat (LAT + 1) q.push_back(idle());
      q.push_back(mk(1, 0, 16'h0010, 16'h0, 2, 0));
      repeat (LAT + 1) q.push_back(idle());
      foreach (q[i]) begin
         drive_cycle(q[i]);
         if ({data_valid, busy, data_out, tag_out, obs_ae} !== {e_v, e_b, last_d, last_t, e_ae}) begin
            failures++;
            $display("FAIL midreset_post cyc=%0d got v=%b b=%b d=%h t=%h ae=%b want v=%b b=%b d=%h t=%h ae=%b",
                     cyc, data_valid, busy, data_out, tag_out, obs_ae, e_v, e_b, last_d, last_t, e_ae);
         end
         checks++;
      end
   endtask

   task automatic test_odd_addr();
      stim_t q[$];
`ifdef MEM_ALIGN_CHECK_EN
      q.push_back(mk(1, 1, 16'h0011, 16'h1234, 0, 0));
      q.push_back(idle());
      q.push_back(mk(1, 0, 16'h0010, 16'h0, 12, 0));
      q.push_back(mk(1, 0, 16'h0011, 16'h0, 13, 0));
`else
      q.push_back(mk(1, 0, 16'h0011, 16'h0, 12, 0));
      q.push_back(mk(1, 1, 16'h0013, 16'h5A5A, 0, 0));
      q.push_back(mk(1, 0, 16'h0012, 16'h0, 13, 0));
`endif
      repeat (LAT + 2) q.push_back(idle());
      foreach (q[i]) begin
         drive_cycle(q[i]);
         if ({data_valid, busy, data_out, tag_out, obs_ae} !== {e_v, e_b, last_d, last_t, e_ae}) begin
            failures++;
            $display("FAIL odd_addr cyc=%0d got v=%b b=%b d=%h t=%h ae=%b want v=%b b=%b d=%h t=%h ae=%b",
                     cyc, data_valid, busy, data_out, tag_out, obs_ae, e_v, e_b, last_d, last_t, e_ae);
         end
         checks++;
      end
   endtask

   task automatic test_random();
      stim_t q[$];
      stim_t s;
      for (int i = 0; i < 8; i++)
         q.push_back(mk(1, 1, 16'(16'h0020 + 2 * i), 16'($urandom), 0, 0));
      for (int i = 0; i < 400; i++) begin
         s.en = ($urandom_range(0, 3) != 0);
         s.w  = ($urandom_range(0, 2) == 0);
         s.a  = 16'(16'h0020 + 2 * $urandom_range(0, 7) + $urandom_range(0, 1));
         s.d  = 16'($urandom);
         s.t  = 4'($urandom_range(0, 15));
         s.fl = ($urandom_range(0, 9) == 0);
         q.push_back(s);
      end
      repeat (LAT + 2) q.push_back(idle());
      foreach (q[i]) begin
         drive_cycle(q[i]);
         if ({data_valid, busy, data_out, tag_out, obs_ae} !== {e_v, e_b, last_d, last_t, e_ae}) begin
            failures++;
            $display("FAIL random cyc=%0d got v=%b b=%b d=%h t=%h ae=%b want v=%b b=%b d=%h t=%h ae=%b",
                     cyc, data_valid, busy, data_out, tag_out, obs_ae, e_v, e_b, last_d, last_t, e_ae);
         end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_raw_latency();
      test_back_to_back();
      test_bubble();
      test_flush();
      test_reset_midflight();
      test_odd_addr();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
